// File: rtl/bblock_sig_gen.sv
// Runtime basic-block signature generator for the NP core control-flow monitor.
// Retired instruction words are folded into a rolling XOR/rotate signature. A block
// closes on a branch/jump or when it reaches MAX_BB_LEN instructions. The completed
// {signature, start PC} pair is then held in a valid/ready output register.
module bblock_sig_gen #(
  parameter int unsigned PC_W       = 32,
  parameter int unsigned SIG_W      = 32,
  parameter int unsigned MAX_BB_LEN = 64
) (
  input  logic             core_sp_clk,
  input  logic             reset,
  input  logic             pkt_start,
  input  logic             instr_valid,
  input  logic [PC_W-1:0]  instr_pc,
  input  logic [SIG_W-1:0] instr_word,
  input  logic             instr_is_cf,
  input  logic             sig_ready,
  output logic             sig_valid,
  output logic [SIG_W-1:0] jump_bblock,
  output logic [PC_W-1:0]  bblock_addr,
  output logic             stall,
  output logic             bb_overflow,
  output logic             protocol_err
);

  localparam int unsigned LenW = $clog2(MAX_BB_LEN + 1);
  localparam logic [LenW-1:0] MaxLen = LenW'(MAX_BB_LEN);

  typedef enum logic [0:0] {
    StIdle,
    StAccum
  } state_e;

  // Fixed 5-bit left rotate used by the signature fold.
  function automatic logic [SIG_W-1:0] rotl5(input logic [SIG_W-1:0] x);
    return {x[SIG_W-6:0], x[SIG_W-1:SIG_W-5]};
  endfunction

  state_e           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [LenW-1:0]  len_q, len_d;
  logic [PC_W-1:0]  start_pc_q, start_pc_d;

  logic             out_valid_q, out_valid_d;
  logic [SIG_W-1:0] out_sig_q, out_sig_d;
  logic [PC_W-1:0]  out_addr_q, out_addr_d;
  logic             overflow_q, overflow_d;
  logic             perr_q, perr_d;

  logic [SIG_W-1:0] pc_ext;
  logic             accept;
  logic             fresh_block;
  logic [SIG_W-1:0] fold_sig;
  logic [LenW-1:0]  fold_len;
  logic [PC_W-1:0]  fold_start;
  logic             force_close;
  logic             close_blk;

  // The start PC seeds the signature, sized to the signature width.
  if (PC_W >= SIG_W) begin : g_pc_trunc
    assign pc_ext = instr_pc[SIG_W-1:0];
  end else begin : g_pc_zext
    assign pc_ext = {{(SIG_W - PC_W){1'b0}}, instr_pc};
  end

  // Core is held off while a completed block waits for the downstream.
  assign stall  = out_valid_q & ~sig_ready;
  assign accept = instr_valid & ~stall;

  // Fold the incoming instruction into the running (or a freshly started) block.
  always_comb begin
    fold_sig    = '0;
    fold_len    = '0;
    fold_start  = '0;
    // pkt_start discards the partial block, so a same-edge instruction opens a new one.
    fresh_block = pkt_start | (state_q == StIdle);
    if (fresh_block) begin
      fold_sig   = rotl5(pc_ext) ^ instr_word;
      fold_len   = LenW'(1);
      fold_start = instr_pc;
    end else begin
      fold_sig   = rotl5(sig_q) ^ instr_word;
      fold_len   = len_q + LenW'(1);
      fold_start = start_pc_q;
    end
    force_close = (fold_len == MaxLen);
    close_blk   = accept & (instr_is_cf | force_close);
  end

  // Next-state for the block FSM, output register and sticky flags.
  always_comb begin
    state_d     = state_q;
    sig_d       = sig_q;
    len_d       = len_q;
    start_pc_d  = start_pc_q;
    out_valid_d = out_valid_q;
    out_sig_d   = out_sig_q;
    out_addr_d  = out_addr_q;
    overflow_d  = overflow_q;
    perr_d      = perr_q;

    if (pkt_start) begin
      state_d    = StIdle;
      sig_d      = '0;
      len_d      = '0;
      overflow_d = 1'b0;
      perr_d     = 1'b0;
    end

    // A stalled instruction is dropped; only the violation is recorded.
    if (instr_valid && stall) begin
      perr_d = 1'b1;
    end

    // Downstream took the pending block; a same-edge close below reloads it.
    if (out_valid_q && sig_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      unique case (state_q)
        StIdle, StAccum: begin
          if (close_blk) begin
            state_d     = StIdle;
            sig_d       = '0;
            len_d       = '0;
            out_valid_d = 1'b1;
            out_sig_d   = fold_sig;
            out_addr_d  = fold_start;
            if (!instr_is_cf) begin
              overflow_d = 1'b1;
            end
          end else begin
            state_d    = StAccum;
            sig_d      = fold_sig;
            len_d      = fold_len;
            start_pc_d = fold_start;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Block accumulation state.
  always_ff @(posedge core_sp_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      sig_q      <= '0;
      len_q      <= '0;
      start_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      sig_q      <= sig_d;
      len_q      <= len_d;
      start_pc_q <= start_pc_d;
    end
  end

  // Output register and sticky status flags.
  always_ff @(posedge core_sp_clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_sig_q   <= '0;
      out_addr_q  <= '0;
      overflow_q  <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sig_q   <= out_sig_d;
      out_addr_q  <= out_addr_d;
      overflow_q  <= overflow_d;
      perr_q      <= perr_d;
    end
  end

  assign sig_valid    = out_valid_q;
  assign jump_bblock  = out_sig_q;
  assign bblock_addr  = out_addr_q;
  assign bb_overflow  = overflow_q;
  assign protocol_err = perr_q;

endmodule
